// File: rtl/psram_ddr_sequencer.sv
// rtl/psram_ddr_sequencer.sv - single-request PSRAM DDR transaction sequencer
// Produces per-clock ODDR D0/D1/TX values and captures IDDR read data after RD_DELAY.
module psram_ddr_sequencer #(
  parameter int LATENCY     = 6,
  parameter int RD_DELAY    = 4,
  parameter int CS_RECOVERY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [21:0] req_address,
  input  logic [15:0] req_wdata,
  input  logic [1:0]  req_wmask,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic        cs_n,
  output logic        ck_d0,
  output logic        ck_d1,
  output logic [7:0]  dq_d0,
  output logic [7:0]  dq_d1,
  output logic        dq_tx,
  output logic        rwds_d0,
  output logic        rwds_d1,
  output logic        rwds_tx,
  input  logic [15:0] dq_in
);

  typedef enum logic [2:0] {
    IDLE, CMD0, CMD1, CMD2, LAT, DATA, WAIT_RD, RECOV
  } state_t;

  localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);
  localparam logic [7:0] RD_LOAD  = 8'(RD_DELAY - 1);
  localparam logic [7:0] REC_LOAD = 8'(CS_RECOVERY - 1);

  state_t      state, next_state;
  logic [7:0]  cnt, next_cnt;
  logic [47:0] ca_q;
  logic [15:0] wdata_q;
  logic [1:0]  wmask_q;
  logic        write_q;

  logic        accept;
  logic [47:0] ca_req, ca_cur;
  logic [15:0] wdata_cur;
  logic [1:0]  wmask_cur;
  logic        write_cur;
  logic        capture;

  logic       n_cs_n, n_ck_d0, n_dq_tx, n_rwds_d0, n_rwds_d1, n_rwds_tx;
  logic [7:0] n_dq_d0, n_dq_d1;

  assign accept  = (state == IDLE) && req_valid && req_ready;
  assign ca_req  = {~req_write, 1'b0, 1'b1, 10'b0, req_address[21:3], 13'b0, req_address[2:0]};
  // Outputs are registered from next_state, so CMD0 must see the request directly.
  assign ca_cur    = accept ? ca_req    : ca_q;
  assign wdata_cur = accept ? req_wdata : wdata_q;
  assign wmask_cur = accept ? req_wmask : wmask_q;
  assign write_cur = accept ? req_write : write_q;
  assign capture   = (state == WAIT_RD) && (next_state == RECOV);

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      IDLE: if (accept) next_state = CMD0;
      CMD0: next_state = CMD1;
      CMD1: next_state = CMD2;
      CMD2: begin
        next_state = LAT;
        next_cnt   = LAT_LOAD;
      end
      LAT: begin
        if (cnt == 8'd0) next_state = DATA;
        else             next_cnt   = cnt - 8'd1;
      end
      DATA: begin
        if (write_q) begin
          next_state = RECOV;
          next_cnt   = REC_LOAD;
        end else begin
          next_state = WAIT_RD;
          next_cnt   = RD_LOAD;
        end
      end
      WAIT_RD: begin
        if (cnt == 8'd0) begin
          next_state = RECOV;
          next_cnt   = REC_LOAD;
        end else begin
          next_cnt = cnt - 8'd1;
        end
      end
      RECOV: begin
        if (cnt == 8'd0) next_state = IDLE;
        else             next_cnt   = cnt - 8'd1;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    n_cs_n    = 1'b1;
    n_ck_d0   = 1'b0;
    n_dq_tx   = 1'b1;
    n_dq_d0   = 8'h00;
    n_dq_d1   = 8'h00;
    n_rwds_tx = 1'b1;
    n_rwds_d0 = 1'b0;
    n_rwds_d1 = 1'b0;
    case (next_state)
      CMD0, CMD1, CMD2: begin
        n_cs_n  = 1'b0;
        n_ck_d0 = 1'b1;
        n_dq_tx = 1'b0;
        if (next_state == CMD0) begin
          n_dq_d0 = ca_cur[47:40];
          n_dq_d1 = ca_cur[39:32];
        end else if (next_state == CMD1) begin
          n_dq_d0 = ca_cur[31:24];
          n_dq_d1 = ca_cur[23:16];
        end else begin
          n_dq_d0 = ca_cur[15:8];
          n_dq_d1 = ca_cur[7:0];
        end
      end
      LAT, WAIT_RD: begin
        n_cs_n  = 1'b0;
        n_ck_d0 = 1'b1;
      end
      DATA: begin
        n_cs_n  = 1'b0;
        n_ck_d0 = 1'b1;
        if (write_cur) begin
          // RWDS high during a write data beat masks that byte.
          n_dq_tx   = 1'b0;
          n_rwds_tx = 1'b0;
          n_dq_d0   = wdata_cur[15:8];
          n_dq_d1   = wdata_cur[7:0];
          n_rwds_d0 = ~wmask_cur[1];
          n_rwds_d1 = ~wmask_cur[0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      ca_q      <= 48'd0;
      wdata_q   <= 16'd0;
      wmask_q   <= 2'd0;
      write_q   <= 1'b0;
      req_ready <= 1'b0;
      busy      <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 16'd0;
      cs_n      <= 1'b1;
      ck_d0     <= 1'b0;
      ck_d1     <= 1'b0;
      dq_d0     <= 8'h00;
      dq_d1     <= 8'h00;
      dq_tx     <= 1'b1;
      rwds_d0   <= 1'b0;
      rwds_d1   <= 1'b0;
      rwds_tx   <= 1'b1;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (accept) begin
        ca_q    <= ca_req;
        wdata_q <= req_wdata;
        wmask_q <= req_wmask;
        write_q <= req_write;
      end
      req_ready <= (next_state == IDLE);
      busy      <= (next_state != IDLE);
      rsp_valid <= capture;
      if (capture) rsp_rdata <= dq_in;
      cs_n    <= n_cs_n;
      ck_d0   <= n_ck_d0;
      ck_d1   <= 1'b0;
      dq_d0   <= n_dq_d0;
      dq_d1   <= n_dq_d1;
      dq_tx   <= n_dq_tx;
      rwds_d0 <= n_rwds_d0;
      rwds_d1 <= n_rwds_d1;
      rwds_tx <= n_rwds_tx;
    end
  end

endmodule
